// File: rtl/spi_slave_sync.sv
// SPI slave for one sysclk domain, with a TX FIFO. Pins reach the edge detector after 3 cycles; oRx/oRxValid follow a word's last sample by 1 cycle.
// Backpressure: oTxReady drops when the FIFO is full and pushes are then dropped. An empty FIFO at word start sends TXIDLE and pulses oUnderrun.
module spi_slave_sync #(
  parameter int              WIDTH   = 8,
  parameter bit              CPOL    = 1'b0,
  parameter bit              CPHA    = 1'b0,
  parameter int              TXDEPTH = 4,
  parameter logic [WIDTH-1:0] TXIDLE = '1
) (
  input  logic                       sysclk,
  input  logic                       iRstN,
  input  logic                       iSPIClk,
  input  logic                       iSPIMOSI,
  input  logic                       iSPICS,
  output logic                       oSPIMISO,
  output logic [WIDTH-1:0]           oRx,
  output logic                       oRxValid,
  input  logic [WIDTH-1:0]           iTx,
  input  logic                       iTxValid,
  output logic                       oTxReady,
  output logic [$clog2(TXDEPTH):0]   oTxLevel,
  output logic                       oUnderrun,
  output logic                       oFrameErr,
  output logic                       oBusy
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(TXDEPTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(TXDEPTH);

  logic             rstN;
  logic [1:0]       rstPipe;
  logic [1:0]       sckSync, mosiSync, csSync;
  logic             sckDly, csDly;
  logic             csActive, csFall, csRise;
  logic             leadEdge, trailEdge, sampleEdge, shiftEdge;
  logic [CW-1:0]    bitCnt;
  logic [WIDTH-2:0] rxShift;
  logic [WIDTH-1:0] rxNext;
  logic [WIDTH-1:0] txShift;
  logic             wordStart, txLoad, fifoHas;
  logic             txPush, txPop;
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [WIDTH-1:0] txMem [TXDEPTH];
  logic [WIDTH-1:0] fifoHead;

  // Assertion of iRstN is immediate; release is retimed to sysclk.
  always_ff @(posedge sysclk or negedge iRstN) begin
    if (!iRstN) begin
      rstPipe <= 2'b00;
    end else begin
      rstPipe <= {rstPipe[0], 1'b1};
    end
  end
  assign rstN = rstPipe[1];

  always_ff @(posedge sysclk or negedge rstN) begin
    if (!rstN) begin
      sckSync  <= {2{CPOL}};
      mosiSync <= 2'b00;
      csSync   <= 2'b11;
      sckDly   <= CPOL;
      csDly    <= 1'b1;
    end else begin
      sckSync  <= {sckSync[0], iSPIClk};
      mosiSync <= {mosiSync[0], iSPIMOSI};
      csSync   <= {csSync[0], iSPICS};
      sckDly   <= sckSync[1];
      csDly    <= csSync[1];
    end
  end

  assign csActive   = ~csSync[1];
  assign csFall     = csDly & ~csSync[1];
  assign csRise     = ~csDly & csSync[1];
  assign leadEdge   = csActive & (sckDly == CPOL) & (sckSync[1] != CPOL);
  assign trailEdge  = csActive & (sckDly != CPOL) & (sckSync[1] == CPOL);
  assign sampleEdge = CPHA ? trailEdge : leadEdge;
  assign shiftEdge  = CPHA ? leadEdge : trailEdge;
  assign rxNext     = {rxShift, mosiSync[1]};

  always_ff @(posedge sysclk or negedge rstN) begin
    if (!rstN) begin
      bitCnt    <= '0;
      rxShift   <= '0;
      oRx       <= '0;
      oRxValid  <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      oRxValid  <= 1'b0;
      oFrameErr <= 1'b0;
      if (csRise) begin
        bitCnt    <= '0;
        rxShift   <= '0;
        oFrameErr <= (bitCnt != '0);
      end else if (sampleEdge) begin
        rxShift <= rxNext[WIDTH-2:0];
        if (bitCnt == LAST) begin
          bitCnt   <= '0;
          oRx      <= rxNext;
          oRxValid <= 1'b1;
        end else begin
          bitCnt <= bitCnt + 1'b1;
        end
      end
    end
  end

  // A shift edge with the counter at 0 opens a new word: for CPHA=0 that is the edge after the last sample.
  assign wordStart = shiftEdge & (bitCnt == '0);
  assign txLoad    = (CPHA ? 1'b0 : csFall) | wordStart;
  assign fifoHas   = (oTxLevel != '0);
  assign txPop     = txLoad & fifoHas;

  always_ff @(posedge sysclk or negedge rstN) begin
    if (!rstN) begin
      txShift   <= '0;
      oUnderrun <= 1'b0;
    end else begin
      oUnderrun <= txLoad & ~fifoHas;
      if (txLoad) begin
        txShift <= fifoHas ? fifoHead : TXIDLE;
      end else if (shiftEdge) begin
        txShift <= {txShift[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign oSPIMISO = csActive ? txShift[WIDTH-1] : 1'bz;
  assign oBusy    = csActive;

  // TX FIFO; pointers wrap naturally because TXDEPTH is a power of two.
  assign oTxReady = (oTxLevel < FULL);
  assign txPush   = iTxValid & oTxReady;
  assign fifoHead = txMem[rdPtr];

  always_ff @(posedge sysclk or negedge rstN) begin
    if (!rstN) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      oTxLevel <= '0;
    end else begin
      if (txPush) wrPtr <= wrPtr + 1'b1;
      if (txPop)  rdPtr <= rdPtr + 1'b1;
      oTxLevel <= oTxLevel + (AW+1)'(txPush) - (AW+1)'(txPop);
    end
  end

  always_ff @(posedge sysclk) begin
    if (txPush) txMem[wrPtr] <= iTx;
  end
endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a mode-0 8-bit slave and a mode-3 16-bit slave share SCK/MOSI and have separate chip selects.
// A transaction-level model (FIFO queues, word slicing) predicts RX words, MISO bits, underruns, frame errors and FIFO level.
module tb_spi_slave_sync;
  localparam int H = 80;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        iRstN, sck, mosi, cs0, cs3;
  wire         miso0, miso3;
  logic [7:0]  rx0, tx0;
  logic [15:0] rx3, tx3;
  logic        rxv0, txv0, rdy0, ur0, fe0, busy0;
  logic        rxv3, txv3, rdy3, ur3, fe3, busy3;
  logic [2:0]  lvl0, lvl3;

  spi_slave_sync #(.WIDTH(8)) dut0 (
    .sysclk(sysclk), .iRstN(iRstN), .iSPIClk(sck), .iSPIMOSI(mosi), .iSPICS(cs0),
    .oSPIMISO(miso0), .oRx(rx0), .oRxValid(rxv0), .iTx(tx0), .iTxValid(txv0),
    .oTxReady(rdy0), .oTxLevel(lvl0), .oUnderrun(ur0), .oFrameErr(fe0), .oBusy(busy0));

  spi_slave_sync #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .sysclk(sysclk), .iRstN(iRstN), .iSPIClk(sck), .iSPIMOSI(mosi), .iSPICS(cs3),
    .oSPIMISO(miso3), .oRx(rx3), .oRxValid(rxv3), .iTx(tx3), .iTxValid(txv3),
    .oTxReady(rdy3), .oTxLevel(lvl3), .oUnderrun(ur3), .oFrameErr(fe3), .oBusy(busy3));

  int nChecks = 0;
  int nErrors = 0;
  int nRx0 = 0, nUr0 = 0, nFe0 = 0, nRx3 = 0, nUr3 = 0, nFe3 = 0;
  logic [15:0] rxLog0[$], rxLog3[$];
  logic [15:0] q0[$], q3[$];

  always @(negedge sysclk) begin
    if (rxv0) begin nRx0++; rxLog0.push_back({8'h00, rx0}); end
    if (ur0) nUr0++;
    if (fe0) nFe0++;
    if (rxv3) begin nRx3++; rxLog3.push_back(rx3); end
    if (ur3) nUr3++;
    if (fe3) nFe3++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pushWord(input bit m3, input logic [15:0] w);
    bit expRdy;
    @(negedge sysclk);
    expRdy = m3 ? (q3.size() < 4) : (q0.size() < 4);
    if (m3) begin
      check("txReady3", rdy3, expRdy);
      tx3 = w; txv3 = 1'b1;
    end else begin
      check("txReady0", rdy0, expRdy);
      tx0 = w[7:0]; txv0 = 1'b1;
    end
    @(negedge sysclk);
    txv0 = 1'b0; txv3 = 1'b0;
    if (expRdy) begin
      if (m3) q3.push_back(w); else q0.push_back({8'h00, w[7:0]});
    end
    if (m3) check("txLevel3", lvl3, q3.size());
    else    check("txLevel0", lvl0, q0.size());
  endtask

  // Master: mode 0 samples MISO on the leading edge, mode 3 on the trailing edge.
  task automatic spiXfer(input bit m3, input logic [63:0] txBits, input int nBits, output logic [63:0] rxBits);
    rxBits = '0;
    @(negedge sysclk);
    sck = m3;
    #(4*H);
    if (m3) cs3 = 1'b0; else cs0 = 1'b0;
    #(2*H);
    if (m3) check("busy3", busy3, 1); else check("busy0", busy0, 1);
    for (int i = 0; i < nBits; i++) begin
      if (!m3) begin
        mosi = txBits[nBits-1-i];
        #H; sck = 1'b1; rxBits[nBits-1-i] = miso0;
        #H; sck = 1'b0;
      end else begin
        sck = 1'b0; mosi = txBits[nBits-1-i];
        #H; sck = 1'b1; rxBits[nBits-1-i] = miso3;
        #H;
      end
    end
    #H;
    cs0 = 1'b1; cs3 = 1'b1;
    #(4*H);
  endtask

  task automatic runXfer(input bit m3, input int nBits, input logic [63:0] data);
    int w, nFull, part, nLoads, expUr;
    int rxS, urS, feS, otherS;
    logic [15:0] words[$];
    logic [15:0] wd;
    logic [63:0] bits, misoGot, expMiso, wmask;
    w = m3 ? 16 : 8;
    wmask = m3 ? 64'hFFFF : 64'hFF;
    bits = data & ((64'd1 << nBits) - 1);
    nFull = nBits / w;
    part = nBits % w;
    nLoads = m3 ? nFull + ((part != 0) ? 1 : 0) : nFull + 1;
    expUr = 0;
    for (int l = 0; l < nLoads; l++) begin
      if (m3 && q3.size() > 0) wd = q3.pop_front();
      else if (!m3 && q0.size() > 0) wd = q0.pop_front();
      else begin wd = m3 ? 16'hFFFF : 16'h00FF; expUr++; end
      words.push_back(wd);
    end
    expMiso = '0;
    for (int j = 0; j < nBits; j++) begin
      wd = words[j / w];
      expMiso[nBits-1-j] = wd[w-1-(j % w)];
    end
    rxLog0.delete(); rxLog3.delete();
    rxS = m3 ? nRx3 : nRx0;
    urS = m3 ? nUr3 : nUr0;
    feS = m3 ? nFe3 : nFe0;
    otherS = m3 ? nRx0 + nFe0 : nRx3 + nFe3;
    spiXfer(m3, bits, nBits, misoGot);
    check("misoBits", misoGot, expMiso);
    if (m3) begin
      check("rxCount3", nRx3 - rxS, nFull);
      for (int k = 0; k < nFull && k < rxLog3.size(); k++)
        check("rxWord3", rxLog3[k], (bits >> (nBits - (k+1)*w)) & wmask);
      check("underrun3", nUr3 - urS, expUr);
      check("frameErr3", nFe3 - feS, (part != 0) ? 1 : 0);
      check("txLevel3", lvl3, q3.size());
      check("idleDut0", nRx0 + nFe0 - otherS, 0);
    end else begin
      check("rxCount0", nRx0 - rxS, nFull);
      for (int k = 0; k < nFull && k < rxLog0.size(); k++)
        check("rxWord0", rxLog0[k], (bits >> (nBits - (k+1)*w)) & wmask);
      check("underrun0", nUr0 - urS, expUr);
      check("frameErr0", nFe0 - feS, (part != 0) ? 1 : 0);
      check("txLevel0", lvl0, q0.size());
      check("idleDut3", nRx3 + nFe3 - otherS, 0);
    end
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_lvl0"}, lvl0, 0);
    check({tag, "_rdy0"}, rdy0, 1);
    check({tag, "_rx0"}, rx0, 0);
    check({tag, "_rxv0"}, rxv0, 0);
    check({tag, "_ur0"}, ur0, 0);
    check({tag, "_fe0"}, fe0, 0);
    check({tag, "_busy0"}, busy0, 0);
    check({tag, "_lvl3"}, lvl3, 0);
    check({tag, "_rdy3"}, rdy3, 1);
    check({tag, "_rx3"}, rx3, 0);
    check({tag, "_busy3"}, busy3, 0);
  endtask

  initial begin
    int s0, s1;
    iRstN = 1'b0; sck = 1'b0; mosi = 1'b0; cs0 = 1'b1; cs3 = 1'b1;
    tx0 = '0; txv0 = 1'b0; tx3 = '0; txv3 = 1'b0;
    #100;
    checkResetState("rst");
    @(negedge sysclk); iRstN = 1'b1;
    #(200);
    checkResetState("post");

    // Mode 0 basic word: MISO carries the queued 0xA5, MOSI delivers 0x3C.
    pushWord(0, 16'h00A5);
    runXfer(0, 8, 64'h3C);

    // Mode 3, two back-to-back 16-bit words in one frame.
    pushWord(1, 16'hC0DE);
    runXfer(1, 32, 64'h1234BEEF);

    // Empty FIFO underrun, then overfill with five pushes.
    runXfer(1, 16, 64'h5AA5);
    for (int i = 0; i < 5; i++) begin
      pushWord(0, 16'($urandom));
      if (i == 3) check("readyFull0", rdy0, 0);
    end
    runXfer(0, 32, {$urandom, $urandom});

    // Short frame, then a clean word.
    runXfer(0, 3, 64'h5);
    runXfer(0, 8, 64'hC3);

    // Reset in the middle of a word with two words queued.
    pushWord(0, 16'($urandom));
    pushWord(0, 16'($urandom));
    check("lvlBeforeRst", lvl0, 2);
    @(negedge sysclk);
    sck = 1'b0; cs0 = 1'b0;
    #(2*H);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'($urandom);
      #H; sck = 1'b1;
      #H; sck = 1'b0;
    end
    #(H/2);
    iRstN = 1'b0;
    #1;
    checkResetState("midRst");
    cs0 = 1'b1; mosi = 1'b0;
    #(4*H);
    s0 = nRx0 + nFe0 + nUr0;
    s1 = nRx3 + nFe3 + nUr3;
    @(negedge sysclk); iRstN = 1'b1;
    #(20*H);
    check("pulsesAfterRst0", nRx0 + nFe0 + nUr0 - s0, 0);
    check("pulsesAfterRst3", nRx3 + nFe3 + nUr3 - s1, 0);
    checkResetState("relRst");
    q0.delete(); q3.delete();

    // Randomised traffic on both slaves.
    for (int it = 0; it < 20; it++) begin
      bit m3;
      int np, nb;
      m3 = 1'($urandom);
      np = $urandom_range(0, 4);
      for (int p = 0; p < np; p++) pushWord(m3, 16'($urandom));
      nb = m3 ? $urandom_range(1, 48) : $urandom_range(1, 24);
      runXfer(m3, nb, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits (4..32).
REQ-002 SHALL have parameter CPOL, default 0, SCK idle level.
REQ-003 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter TXDEPTH, default 4, TX FIFO depth (power of 2, >=2).
REQ-005 SHALL have parameter TXIDLE, default all-ones, word sent when the TX FIFO is empty.
REQ-006 SHALL have port sysclk  in  1  the single clock; all logic is in this domain.
REQ-007 SHALL have port iRstN  in  1  asynchronous active-low reset.
REQ-008 SHALL have port iSPIClk  in  1  SCK, asynchronous to sysclk.
REQ-009 SHALL have port iSPIMOSI  in  1  MOSI, asynchronous.
REQ-010 SHALL have port iSPICS  in  1  chip select, active-low, asynchronous.
REQ-011 SHALL have port oSPIMISO  out  1  MISO; high-Z while the synchronised CS is high.
REQ-012 SHALL have port oRx  out  WIDTH  last complete received word.
REQ-013 SHALL have port oRxValid  out  1  one-cycle pulse when oRx updates.
REQ-014 SHALL have port iTx  in  WIDTH  word to queue for transmit.
REQ-015 SHALL have port iTxValid  in  1  push request.
REQ-016 SHALL have port oTxReady  out  1  FIFO not full.
REQ-017 SHALL have port oTxLevel  out  $clog2(TXDEPTH)+1  FIFO occupancy.
REQ-018 SHALL have port oUnderrun  out  1  one-cycle pulse when TXIDLE is substituted.
REQ-019 SHALL have port oFrameErr  out  1  one-cycle pulse when CS rises mid-word.
REQ-020 SHALL have port oBusy  out  1  synchronised CS asserted.

Function
REQ-021 SHALL pass SCK, MOSI and CS through 2-flop synchronisers; SCK edges are detected from the synchronised value (3-cycle input latency); sysclk SHALL be >= 4x SCK.
REQ-022 Leading edge = SCK leaving CPOL; trailing edge = SCK returning to CPOL; sample edge and shift edge follow CPHA per REQ-003.
REQ-023 SHALL shift MOSI in MSB first on each sample edge while CS is low; bit counter 0..WIDTH-1 wraps to 0 after WIDTH samples.
REQ-024 On the WIDTH-th sample SHALL load oRx with the full word (including that bit) and pulse oRxValid on the next sysclk cycle; back-to-back words within one CS are supported with no gap.
REQ-025 TX shift register SHALL load at word start: CPHA=0 on CS-assert detection and on the shift edge after the WIDTH-th sample; CPHA=1 on the leading edge with bit counter 0.
REQ-026 Word load SHALL pop the FIFO head if oTxLevel > 0; otherwise it SHALL load TXIDLE and pulse oUnderrun.
REQ-027 SHALL drive MISO from the TX register MSB, advancing one bit per shift edge; CPHA=0 presents the MSB before the first leading edge.
REQ-028 Push SHALL occur on iTxValid && oTxReady; push while full SHALL be ignored, with FIFO contents unchanged.
REQ-029 Push and pop in the same cycle SHALL leave oTxLevel unchanged; push with pop on empty SHALL substitute TXIDLE, store the pushed word, and set oTxLevel=1.
REQ-030 FIFO pointers SHALL wrap modulo TXDEPTH; oTxReady = (oTxLevel < TXDEPTH).
REQ-031 CS deassert SHALL clear the bit counter and RX shift register and discard any partial word; if bit counter != 0, it SHALL pulse oFrameErr. The FIFO SHALL be untouched.
REQ-032 SCK edges while CS is high SHALL be ignored.

Reset
REQ-033 iRstN low SHALL asynchronously clear: synchronisers to idle (SCK=CPOL, CS=1), counters, shift registers, FIFO (oTxLevel=0, oTxReady=1), oRx=0, oRxValid=0, oUnderrun=0, oFrameErr=0, oBusy=0, MISO high-Z.
REQ-034 Reset release SHALL be synchronous to sysclk; reset mid-transfer SHALL abandon the transfer with no oRxValid or oFrameErr pulse.

Verification
REQ-035 WIDTH=8, mode 0: push 0xA5, then CS low and clock 0x3C -> oRx=0x3C with a single oRxValid pulse, MISO bits = 10100101, oTxLevel back to 0.
REQ-036 Mode 3 (CPOL=1, CPHA=1), WIDTH=16: two back-to-back words 0x1234, 0xBEEF in one CS -> two oRxValid pulses with matching values.
REQ-037 FIFO empty, transfer one word -> MISO = TXIDLE, one oUnderrun pulse; push 5 words with TXDEPTH=4 -> 5th ignored, oTxReady=0 at level 4.
REQ-038 Raise CS after 3 bits -> oFrameErr pulse, no oRxValid; the next full word is received correctly.
REQ-039 Assert iRstN low mid-word with FIFO level 2 -> all outputs at reset values, oTxLevel=0, no pulses on release.
